// File: rtl/rv_pkg.sv
// Shared constants for the fetch front end: default datapath width,
// the canonical NOP encoding (addi x0, x0, 0) and the default reset PC.
package rv_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/fq_storage.sv
// Instruction queue storage: DEPTH entries of {pc, instr}, one synchronous
// write port and an asynchronous read port addressed by the read pointer.
// Entries carry no reset; validity is tracked by the owner's count.
module fq_storage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [XLEN-1:0]          wr_pc,
  input  logic [XLEN-1:0]          wr_instr,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_instr
);

  logic [2*XLEN-1:0] mem [DEPTH];

  // Capture a returned fetch into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {wr_pc, wr_instr};
    end
  end

  assign {rd_pc, rd_instr} = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry instruction queue between the synchronous
// instruction memory and decode. One fetch is issued per cycle while the
// queue (counting the in-flight request) has room; execute corrections and
// decode predictions flush the queue and steer the fetch address in the
// same cycle. Optional feature macro: FETCH_QUEUE_BYPASS_EN lets a response
// arriving at an empty queue appear at the head in its arrival cycle.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic [XLEN-1:0]        IMemAddr_o,
  input  logic [XLEN-1:0]        IMemData_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirectPC_i,
  input  logic                   predict_i,
  input  logic [XLEN-1:0]        predictPC_i,
  output logic                   FD_valid_o,
  input  logic                   FD_ready_i,
  output logic [XLEN-1:0]        FD_PC_o,
  output logic [XLEN-1:0]        FD_instr_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Sequential fetch PC (next address when no redirect)
  logic [XLEN-1:0] pc_p0;
  // Request issued last cycle; its data is on IMemData_i this cycle
  logic            req_vld_p1;
  logic [XLEN-1:0] req_pc_p1;

  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] last_pc;

  logic            flush;
  logic            issue;
  logic            pop;
  logic            deq;
  logic            push;
  logic            q_valid;
  logic            byp_vld;
  logic [CW:0]     occ;
  logic [XLEN-1:0] q_pc;
  logic [XLEN-1:0] q_instr;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;

  // Fetch address select: correction beats prediction beats sequential
  always_comb begin
    IMemAddr_o = pc_p0;
    if (!reset_i) begin
      IMemAddr_o = RESET_PC;
    end else if (redirect_i) begin
      IMemAddr_o = redirectPC_i;
    end else if (predict_i) begin
      IMemAddr_o = predictPC_i;
    end
  end

  // Head selection, handshake and queue occupancy bookkeeping
  always_comb begin
    flush   = redirect_i | predict_i;
    q_valid = (count != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp_vld = !q_valid & req_vld_p1 & !flush;
`else
    byp_vld = 1'b0;
`endif
    FD_valid_o = q_valid | byp_vld;
    head_pc    = q_valid ? q_pc    : req_pc_p1;
    head_instr = q_valid ? q_instr : IMemData_i;
    FD_PC_o    = FD_valid_o ? head_pc    : last_pc;
    FD_instr_o = FD_valid_o ? head_instr : XLEN'(NOP_INSTR);
    pop  = FD_valid_o & FD_ready_i;
    // A flushed head is not consumed; a bypassed head never touches storage
    deq  = pop & q_valid & !flush;
    push = req_vld_p1 & !flush & !(byp_vld & pop);
    // Occupancy the queue will reach once the in-flight word lands
    occ   = {1'b0, count} + (CW+1)'(req_vld_p1) - (CW+1)'(pop);
    issue = flush | (occ < (CW+1)'(DEPTH));
    count_o = count;
  end

  // Control state: fetch PC, request valid, pointers, count, held head PC
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pc_p0      <= RESET_PC;
      req_vld_p1 <= 1'b0;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      last_pc    <= '0;
    end else begin
      req_vld_p1 <= issue;
      if (issue) begin
        pc_p0 <= IMemAddr_o + XLEN'(4);
      end
      last_pc <= FD_PC_o;
      if (flush) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        count <= count + CW'(push) - CW'(deq);
        if (deq) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Remember the address of the request now in flight
  always_ff @(posedge clk_i) begin
    if (issue) begin
      req_pc_p1 <= IMemAddr_o;
    end
  end

  fq_storage #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk      (clk_i),
    .wr_en    (push),
    .wr_ptr   (wr_ptr),
    .wr_pc    (req_pc_p1),
    .wr_instr (IMemData_i),
    .rd_ptr   (rd_ptr),
    .rd_pc    (q_pc),
    .rd_instr (q_instr)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue (DEPTH=4, XLEN=32). A synchronous memory model
// returns a PC-derived word; stimulus loads the expected head stream into a
// scoreboard queue and a negedge monitor checks every accepted head.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset_i;
  logic [31:0] IMemAddr_o;
  logic [31:0] IMemData_i;
  logic        redirect_i;
  logic [31:0] redirectPC_i;
  logic        predict_i;
  logic [31:0] predictPC_i;
  logic        FD_valid_o;
  logic        FD_ready_i;
  logic [31:0] FD_PC_o;
  logic [31:0] FD_instr_o;
  logic [2:0]  count_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .IMemAddr_o   (IMemAddr_o),
    .IMemData_i   (IMemData_i),
    .redirect_i   (redirect_i),
    .redirectPC_i (redirectPC_i),
    .predict_i    (predict_i),
    .predictPC_i  (predictPC_i),
    .FD_valid_o   (FD_valid_o),
    .FD_ready_i   (FD_ready_i),
    .FD_PC_o      (FD_PC_o),
    .FD_instr_o   (FD_instr_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Synchronous instruction memory: word for last cycle's address
  always @(posedge clk) IMemData_i <= mem_word(IMemAddr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [31:0] base);
    exp_q.delete();
    for (int k = 0; k < 40; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  // Scoreboard monitor: every accepted, non-flushed head is compared
  always @(negedge clk) begin
    if (reset_i && FD_valid_o && FD_ready_i && !redirect_i && !predict_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected actual_pc=%h required=none", FD_PC_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("head_pc", FD_PC_o, mon_exp);
        check("head_instr", FD_instr_o, mem_word(mon_exp));
      end
    end
  end

  task automatic do_reset();
    reset_i = 1'b0;
    FD_ready_i = 1'b0;
    redirect_i = 1'b0;
    predict_i = 1'b0;
    exp_q.delete();
    tick();
    tick();
  endtask

  initial begin
    redirectPC_i = 32'h0;
    predictPC_i  = 32'h0;
    do_reset();
    check("rst_valid", 32'(FD_valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_instr", FD_instr_o, NOP);
    check("rst_pc", FD_PC_o, 32'h0);
    check("rst_addr", IMemAddr_o, 32'h0);

    // Stall from reset release: fill to DEPTH, then drain in order
    restart(32'h0);
    reset_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c >= 5) begin
        check("stall_valid", 32'(FD_valid_o), 32'd1);
        check("stall_pc", FD_PC_o, 32'h0);
        check("stall_instr", FD_instr_o, mem_word(32'h0));
      end
      if (c == 9) begin
        check("full_count", 32'(count_o), 32'd4);
        check("full_addr", IMemAddr_o, 32'h10);
      end
      tick();
    end
    FD_ready_i = 1'b1;
    repeat (10) tick();

    // Streaming from reset with decode always ready
    do_reset();
    restart(32'h0);
    reset_i = 1'b1;
    FD_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("stream_addr", IMemAddr_o, 32'(4 * c));
      check("stream_valid", 32'(FD_valid_o), (c >= LAT) ? 32'd1 : 32'd0);
      tick();
    end

    // Correction with three queued entries and one fetch in flight
    do_reset();
    reset_i = 1'b1;
    repeat (4) tick();
    check("pre_redirect_count", 32'(count_o), 32'd3);
    redirect_i = 1'b1;
    redirectPC_i = 32'h100;
    FD_ready_i = 1'b1;
    restart(32'h100);
    #1;
    check("redirect_addr", IMemAddr_o, 32'h100);
    tick();
    redirect_i = 1'b0;
    check("post_redirect_count", 32'(count_o), 32'd0);
    repeat (8) tick();

    // Simultaneous correction and prediction: correction wins
    redirect_i = 1'b1;
    redirectPC_i = 32'h200;
    predict_i = 1'b1;
    predictPC_i = 32'h300;
    restart(32'h200);
    #1;
    check("both_addr", IMemAddr_o, 32'h200);
    tick();
    redirect_i = 1'b0;
    predict_i = 1'b0;
    repeat (6) tick();
    check("both_valid", 32'(FD_valid_o), 32'd1);

    // Prediction while head valid and ready: head dropped, target next
    predict_i = 1'b1;
    predictPC_i = 32'h40;
    restart(32'h40);
    #1;
    check("predict_addr", IMemAddr_o, 32'h40);
    tick();
    predict_i = 1'b0;
    repeat (6) tick();

    // Mid-stream reset with two queued entries
    redirect_i = 1'b1;
    redirectPC_i = 32'h500;
    FD_ready_i = 1'b0;
    restart(32'h500);
    tick();
    redirect_i = 1'b0;
    tick();
    tick();
    check("pre_reset_count", 32'(count_o), 32'd2);
    reset_i = 1'b0;
    exp_q.delete();
    tick();
    reset_i = 1'b1;
    #1;
    check("midrst_valid", 32'(FD_valid_o), 32'd0);
    check("midrst_count", 32'(count_o), 32'd0);
    check("midrst_addr", IMemAddr_o, 32'h0);
    check("midrst_instr", FD_instr_o, NOP);
    restart(32'h0);
    FD_ready_i = 1'b1;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-entry fetch stage. It decouples instruction memory from decode with a DEPTH-entry instruction queue and issues one fetch per cycle while space remains. Redirects from execute (correction) and decode (prediction) are applied with zero bubble. It sits between the synchronous instruction memory and the DecodeUnit, replacing the stall/flush-driven fetch register with a valid/ready handshake.

## Interface
Parameters:
- XLEN, 32: PC/instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  reset, synchronous, active-low.
- IMemAddr_o  out  XLEN  fetch address; memory returns its word on IMemData_i one cycle later.
- IMemData_i  in  XLEN  instruction word for the previous cycle's IMemAddr_o.
- redirect_i  in  1  execute-stage PC correction.
- redirectPC_i  in  XLEN  correction target.
- predict_i  in  1  decode-stage predicted-taken redirect.
- predictPC_i  in  XLEN  prediction target.
- FD_valid_o  out  1  head entry valid.
- FD_ready_i  in  1  decode accepts head this cycle.
- FD_PC_o  out  XLEN  PC of head entry.
- FD_instr_o  out  XLEN  instruction of head entry; NOP (32'h0000_0013) when !FD_valid_o.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State: pc register, reqValid (fetch in flight), reqPC, circular queue (rdPtr, wrPtr, count).
- pop = FD_valid_o & FD_ready_i.
- Address select, priority high→low: redirect_i → redirectPC_i; predict_i → predictPC_i; otherwise pc.
- issue = redirect_i | predict_i | (count + reqValid − pop < DEPTH).
- On issue: reqValid←1, reqPC←IMemAddr_o, pc←IMemAddr_o+4. Without issue: reqValid←0, pc holds.
- Response: when reqValid is set and no flush occurs this cycle, {reqPC, IMemData_i} is pushed at wrPtr.
- Flush (redirect_i | predict_i):
  - queue emptied (rdPtr=wrPtr, count=0);
  - in-flight response discarded;
  - pop ignored: a head asserted that cycle is not consumed.
  - Decode raises predict_i only when it is not asserting FD_ready_i for a younger instruction.
- Simultaneous redirect_i and predict_i: redirect wins; predictPC_i is ignored.
- Full: count==DEPTH only when pop=0; no issue then, so a push can never overflow.
- Empty: FD_valid_o=0, FD_instr_o=NOP, FD_PC_o holds its last value.
- Pointers wrap modulo DEPTH. PC arithmetic wraps modulo 2^XLEN.

## Timing
- Reset (reset_i=0 at an edge): pc=RESET_PC, reqValid=0, count=0, pointers 0, FD_valid_o=0, FD_instr_o=NOP, FD_PC_o=0, count_o=0. IMemAddr_o=RESET_PC during reset.
- Reset asserted mid-operation discards queue and in-flight request at that edge.
- Fetch latency (no bypass): address in cycle N → data pushed at end of N+1 → FD_valid_o in N+2.
- Redirect latency: redirect in cycle N → target address driven combinationally in N → target instruction at head in N+2 (N+1 with bypass).
- Throughput: one instruction per cycle sustained when FD_ready_i stays high, for any DEPTH≥2.
- Handshake: FD_PC_o/FD_instr_o stable while FD_valid_o & !FD_ready_i, absent flush.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - when the queue is empty and a valid response arrives without flush, it drives FD_valid_o/FD_PC_o/FD_instr_o combinationally in the same cycle;
  - if popped that cycle it is not written; otherwise it is written normally.
- Undefined: all responses pass through the queue; outputs are driven only from storage, one cycle later.

## Structure
- Shared package rv_pkg: XLEN default, NOP_INSTR constant (32'h0000_0013), RESET_PC default.
- One sub-module, fq_storage: DEPTH×(2·XLEN) register array with write port and asynchronous read at rdPtr. Pointer, count and issue logic stay in fetch_queue.

## Test plan
- Reset release, FD_ready_i=1 → IMemAddr_o sequence 0,4,8,…; FD_PC_o=0 first valid in cycle 2 (cycle 1 with bypass); then one instruction per cycle.
- FD_ready_i=0 for 10 cycles, DEPTH=4 → count_o saturates at 4; issues stop; contents are PCs 0,4,8,12 in order; release drains them in order with no duplicates.
- redirect_i with redirectPC_i=32'h100 while count_o=3 and a fetch is in flight → IMemAddr_o=32'h100 same cycle; count_o=0 next cycle; the next valid head has PC 32'h100.
- redirect_i (32'h200) and predict_i (32'h300) in the same cycle → next valid head has PC 32'h200.
- predict_i=1 with predictPC_i=32'h40 while head valid and FD_ready_i=1 → head not consumed; next head is PC 32'h40.
- reset_i low for one cycle mid-stream with count_o=2 → next cycle FD_valid_o=0, count_o=0, IMemAddr_o=RESET_PC.
